// File: rtl/spi_adc_scanner.sv
// SPI master that pulses the ADC reset, then scans NUM_CH channels round-robin
// (SPI mode 0, MSB first) and hands each result over a valid/ready port.
module spi_adc_scanner #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned FRAME_W      = 16,
  parameter int unsigned RESULT_W     = 12,
  parameter int unsigned CLK_DIV      = 25,
  parameter int unsigned RESET_CYCLES = 50,
  localparam int unsigned CH_W        = $clog2(NUM_CH)
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RESULT_W-1:0] res_data,
  output logic [CH_W-1:0]     res_ch,
  output logic                overrun,
  output logic                RESET_ADC,
  output logic                SPI_SS,
  output logic                SPI_CLOCK,
  output logic                SPI_MOSI,
  input  logic                SPI_MISO
);

  localparam int unsigned CNT_MAX  = (RESET_CYCLES > CLK_DIV) ? RESET_CYCLES : CLK_DIV;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W    = $clog2(FRAME_W);
  localparam int unsigned DIV_LAST = CLK_DIV - 1;
  localparam int unsigned RST_LAST = (RESET_CYCLES > 0) ? RESET_CYCLES - 1 : 0;

  typedef enum logic [2:0] {ADC_RST, IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

  localparam state_t RST_STATE = (RESET_CYCLES > 0) ? ADC_RST : IDLE;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [CH_W-1:0]     ch, ch_next;
  logic [FRAME_W-2:0]  tx_sr;
  logic [RESULT_W-1:0] rx_sr;
  logic [FRAME_W-1:0]  cmd;
  logic                cnt_done, frame_start, frame_end;

  assign busy = (state != IDLE);

  always_comb begin
    cnt_done = (cnt == CNT_W'(DIV_LAST));
    if (state == ADC_RST) cnt_done = (cnt == CNT_W'(RST_LAST));

    ch_next = '0;
    if (state != IDLE && ch < CH_W'(NUM_CH - 1)) ch_next = ch + 1'b1;

    cmd = '0;
    cmd[FRAME_W-3 -: CH_W] = ch_next;

    state_next = state;
    case (state)
      ADC_RST:  if (cnt_done) state_next = IDLE;
      IDLE:     if (start || continuous) state_next = CS_SETUP;
      CS_SETUP: if (cnt_done) state_next = SHIFT;
      SHIFT:    if (cnt_done && SPI_CLOCK && bit_cnt == BIT_W'(FRAME_W - 1)) state_next = CS_HOLD;
      CS_HOLD:  if (cnt_done) state_next = GAP;
      GAP:
        if (cnt_done)
          state_next = (ch < CH_W'(NUM_CH - 1) || continuous) ? CS_SETUP : IDLE;
      default:  state_next = ADC_RST;
    endcase

    frame_start = (state_next == CS_SETUP) && (state != CS_SETUP);
    frame_end   = (state == CS_HOLD) && cnt_done;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= RST_STATE;
    else       state <= state_next;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt       <= '0;
      bit_cnt   <= '0;
      ch        <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      RESET_ADC <= (RESET_CYCLES > 0);
      SPI_SS    <= 1'b1;
      SPI_CLOCK <= 1'b0;
      SPI_MOSI  <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ch    <= '0;
      overrun   <= 1'b0;
    end else begin
      cnt <= (cnt_done || state == IDLE) ? '0 : cnt + 1'b1;

      if (state == ADC_RST && cnt_done) RESET_ADC <= 1'b0;

      if (frame_start) begin
        ch       <= ch_next;
        SPI_SS   <= 1'b0;
        SPI_MOSI <= cmd[FRAME_W-1];
        tx_sr    <= cmd[FRAME_W-2:0];
        bit_cnt  <= '0;
      end

      // Each half-period toggles SCLK: sample MISO on the rise, advance MOSI on the fall.
      if (state == SHIFT && cnt_done) begin
        SPI_CLOCK <= ~SPI_CLOCK;
        if (!SPI_CLOCK) begin
          rx_sr <= {rx_sr[RESULT_W-2:0], SPI_MISO};
        end else begin
          bit_cnt  <= bit_cnt + 1'b1;
          SPI_MOSI <= tx_sr[FRAME_W-2];
          tx_sr    <= {tx_sr[FRAME_W-3:0], 1'b0};
        end
      end

      if (frame_end) begin
        SPI_SS    <= 1'b1;
        res_data  <= rx_sr;
        res_ch    <= ch;
        res_valid <= 1'b1;
        if (res_valid && !res_ready) overrun <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_adc_scanner.sv
// Directed/random bench for spi_adc_scanner with a pin-level ADC model and
// result scoreboard derived from the frame/channel rules.
module tb_spi_adc_scanner;

  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned RESULT_W  = 12;
  localparam int unsigned CLK_DIV   = 2;
  localparam int unsigned RST_CYC   = 50;
  localparam int unsigned CH_W      = 2;
  localparam int unsigned FRAME_LEN = CLK_DIV * (2 * FRAME_W + 2);
  localparam int unsigned CMD_SHIFT = FRAME_W - 2 - CH_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, start, continuous, res_ready, spi_miso;
  logic                busy, res_valid, overrun, reset_adc, spi_ss, spi_clock, spi_mosi;
  logic [RESULT_W-1:0] res_data;
  logic [CH_W-1:0]     res_ch;

  spi_adc_scanner #(
    .NUM_CH(NUM_CH), .FRAME_W(FRAME_W), .RESULT_W(RESULT_W),
    .CLK_DIV(CLK_DIV), .RESET_CYCLES(RST_CYC)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .continuous(continuous),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ch(res_ch), .overrun(overrun),
    .RESET_ADC(reset_adc), .SPI_SS(spi_ss), .SPI_CLOCK(spi_clock),
    .SPI_MOSI(spi_mosi), .SPI_MISO(spi_miso)
  );

  int n_chk = 0;
  int n_err = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [FRAME_W-1:0] words   [64];
  int unsigned        f_fall  [64];
  int unsigned        f_rise  [64];
  logic [FRAME_W-1:0] f_mosi  [64];
  int                 f_rises [64];
  logic               f_vld   [64];
  int unsigned n_fall = 0;
  int unsigned n_done = 0;
  int          rises  = 0;
  int          cur    = 0;
  logic        in_frame = 1'b0;
  logic        prev_ss = 1'b1, prev_sclk = 1'b0;
  logic [FRAME_W-1:0] mosi_acc;

  logic [CH_W+RESULT_W-1:0] got_q[$];
  logic [CH_W+RESULT_W-1:0] exp_q[$];

  // ADC model: drives MISO on SS fall / SCLK fall, records each completed frame.
  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      spi_miso = 1'b0;
    end else begin
      if (prev_ss && !spi_ss) begin
        cur      = int'(n_fall % 64);
        n_fall   = n_fall + 1;
        in_frame = 1'b1;
        rises    = 0;
        mosi_acc = '0;
        f_fall[cur] = cyc;
        spi_miso = words[cur][FRAME_W-1];
      end else if (in_frame && prev_sclk && !spi_clock) begin
        spi_miso = (rises < int'(FRAME_W)) ? words[cur][FRAME_W-1-rises] : 1'b0;
      end
      if (in_frame && !prev_sclk && spi_clock) begin
        mosi_acc = {mosi_acc[FRAME_W-2:0], spi_mosi};
        rises    = rises + 1;
      end
      if (in_frame && !prev_ss && spi_ss) begin
        f_rise[cur]  = cyc;
        f_mosi[cur]  = mosi_acc;
        f_rises[cur] = rises;
        f_vld[cur]   = res_valid;
        n_done       = n_done + 1;
        in_frame     = 1'b0;
      end
    end
    prev_ss   = spi_ss;
    prev_sclk = spi_clock;
  end

  always @(negedge clk)
    if (!reset && res_valid && res_ready) got_q.push_back({res_ch, res_data});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_rst_pulse(input string tag);
    int n;
    n = 0;
    while (reset_adc === 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    chk({tag, "_len"}, n, RST_CYC);
    chk({tag, "_busy_low"}, busy, 1'b0);
  endtask

  task automatic wait_idle(input int max, output int unsigned t);
    int n;
    n = 0;
    while (busy === 1'b1 && n < max) begin @(posedge clk); #1; n++; end
    chk("idle_reached", busy, 1'b0);
    t = cyc;
  endtask

  task automatic wait_done(input int unsigned target);
    int n;
    n = 0;
    while (n_done < target && n < 2000) begin @(posedge clk); #1; n++; end
    chk("frame_done_wait", n_done >= target, 1'b1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_frames(input int unsigned base, input int unsigned cnt);
    for (int unsigned i = 0; i < cnt; i++) begin
      int unsigned k, c;
      k = (base + i) % 64;
      c = i % NUM_CH;
      chk("frame_len", f_rise[k] - f_fall[k], FRAME_LEN);
      chk("frame_sclk_rises", f_rises[k], FRAME_W);
      chk("mosi_cmd", f_mosi[k], c << CMD_SHIFT);
      chk("valid_at_ss_rise", f_vld[k], 1'b1);
      if (i > 0) chk("frame_gap", f_fall[k] - f_rise[(k + 63) % 64], CLK_DIV);
      exp_q.push_back({CH_W'(c), words[k][RESULT_W-1:0]});
    end
  endtask

  task automatic check_results();
    chk("result_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("result_item", got_q[i], exp_q[i]);
  endtask

  initial begin
    int unsigned base, t_idle, t_fall;
    int n;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; res_ready = 1'b1;
    for (int i = 0; i < 64; i++) words[i] = FRAME_W'($urandom);

    // Reset values and ADC reset pulse length.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_reset_adc", reset_adc, 1'b1);
    chk("rst_ss", spi_ss, 1'b1);
    chk("rst_sclk", spi_clock, 1'b0);
    chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_data", res_data, 0);
    chk("rst_ch", res_ch, 0);
    chk("rst_overrun", overrun, 1'b0);
    wait_rst_pulse("adc_rst");

    // Single scan, with a second start pulse while busy that must be ignored.
    repeat ($urandom_range(2, 15)) @(posedge clk);
    base = n_fall;
    words[base + 2][RESULT_W-1:0] = 12'hA5C;
    got_q.delete(); exp_q.delete();
    pulse_start();
    chk("ss_low_after_start", spi_ss, 1'b0);
    chk("busy_after_start", busy, 1'b1);
    repeat (100) @(posedge clk);
    pulse_start();
    wait_idle(2000, t_idle);
    chk("scan_frames", n_done - base, NUM_CH);
    check_frames(base, NUM_CH);
    chk("busy_fall_delay", t_idle - f_rise[base + NUM_CH - 1], CLK_DIV);
    check_results();
    if (got_q.size() > 2) chk("ch2_result", got_q[2][RESULT_W-1:0], 12'hA5C);
    repeat (300) @(posedge clk);
    #1 chk("no_extra_frame", n_fall - base, NUM_CH);

    // Overrun: ready held low across frames 0 and 1.
    res_ready = 1'b0;
    base = n_fall;
    pulse_start();
    wait_done(base + 1);
    chk("ovr_f0_valid", res_valid, 1'b1);
    chk("ovr_f0_data", res_data, words[base][RESULT_W-1:0]);
    chk("ovr_f0_ch", res_ch, 0);
    chk("ovr_f0_flag", overrun, 1'b0);
    repeat (30) @(posedge clk);
    #1 chk("ovr_data_hold", res_data, words[base][RESULT_W-1:0]);
    wait_done(base + 2);
    chk("ovr_f1_data", res_data, words[base + 1][RESULT_W-1:0]);
    chk("ovr_f1_ch", res_ch, 1);
    chk("ovr_f1_flag", overrun, 1'b1);
    res_ready = 1'b1;
    wait_idle(2000, t_idle);
    chk("ovr_sticky", overrun, 1'b1);

    // Ready rising on the very cycle of the frame-1 load retires the old result.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("ovr_cleared_by_reset", overrun, 1'b0);
    wait_rst_pulse("adc_rst2");
    res_ready = 1'b0;
    base = n_fall;
    pulse_start();
    wait_done(base + 1);
    n = 0;
    while (n_fall < base + 2 && n < 200) begin @(posedge clk); #1; n++; end
    chk("f1_started", n_fall >= base + 2, 1'b1);
    t_fall = f_fall[(base + 1) % 64];
    n = 0;
    while (cyc < t_fall + FRAME_LEN - 1 && n < 200) begin @(posedge clk); #1; n++; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("same_cycle_ready_overrun", overrun, 1'b0);
    chk("same_cycle_ready_valid", res_valid, 1'b1);
    chk("same_cycle_ready_data", res_data, words[(base + 1) % 64][RESULT_W-1:0]);
    wait_idle(2000, t_idle);
    chk("no_overrun_end", overrun, 1'b0);

    // Continuous for 2.5 scans, then dropped: scan 3 must still complete.
    repeat ($urandom_range(2, 15)) @(posedge clk);
    base = n_fall;
    got_q.delete(); exp_q.delete();
    #1 continuous = 1'b1;
    n = 0;
    while (n_fall < base + 2 * NUM_CH + NUM_CH / 2 + 1 && n < 5000) begin @(posedge clk); #1; n++; end
    continuous = 1'b0;
    wait_idle(3000, t_idle);
    chk("cont_frames", n_done - base, 3 * NUM_CH);
    check_frames(base, 3 * NUM_CH);
    chk("scan_period", f_fall[(base + NUM_CH) % 64] - f_fall[base % 64],
        NUM_CH * CLK_DIV * (2 * FRAME_W + 3));
    check_results();

    // Reset in the middle of SHIFT (bit 7 high phase) aborts the frame.
    repeat ($urandom_range(2, 15)) @(posedge clk);
    base = n_fall;
    got_q.delete();
    pulse_start();
    n = 0;
    while ((n_fall == base || rises < 8) && n < 500) begin @(posedge clk); #1; n++; end
    chk("bit7_reached", rises, 8);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_ss", spi_ss, 1'b1);
    chk("abort_sclk", spi_clock, 1'b0);
    chk("abort_valid", res_valid, 1'b0);
    chk("abort_reset_adc", reset_adc, 1'b1);
    reset = 1'b0;
    wait_rst_pulse("adc_rst3");
    repeat (200) @(posedge clk);
    #1;
    chk("abort_no_result", got_q.size(), 0);
    chk("abort_no_frame", n_done - base, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
